tapper_lane_engine: RTL and testbench
=====================================

# tapper_lane_engine

Parametrised game-state engine for the bar-tapper game: tracks NUM_LANES lanes, each with one sliding cup and one advancing customer. It handles throws, hits, misses, score and lives, and runs a three-state game FSM. It sits between the debounced key/switch logic and the VGA pixel-draw logic, which reads the flattened position and status outputs each frame. It generalises the fixed four-lane, hard-coded gameplay into configurable lane count, speeds, sizes and lives, and adds customer motion, collision scoring, misses and game-over.

## Interface
Parameters:
- NUM_LANES, 4, number of lanes (2..8)
- LANE_W, 2, width of lane index; must satisfy 2^LANE_W >= NUM_LANES
- X_WIDTH, 10, width of every x coordinate
- PLAYER_X, 400, bartender x; cups launch at PLAYER_X-CUP_W
- CUS_MIN_X, 60, customer spawn x
- CUP_W, 20, cup width in pixels
- CUST_W, 20, customer width in pixels
- CUP_DELAY, 1000000, clocks per cup step
- CUST_DELAY, 4000000, clocks per customer step
- CUP_STEP, 1, pixels per cup step
- CUST_STEP, 1, pixels per customer step
- LIVES, 3, starting lives (1..7)

Ports:
- clk  in  1  system clock, 50 MHz
- rst  in  1  asynchronous active-low reset
- start  in  1  single-cycle pulse that starts a new game
- throw_valid  in  1  single-cycle pulse that throws a cup
- throw_lane  in  LANE_W  lane of the throw
- cup_x  out  NUM_LANES*X_WIDTH  cup x per lane; lane i in bits [i*X_WIDTH +: X_WIDTH]
- cup_active  out  NUM_LANES  cup i is sliding
- cust_x  out  NUM_LANES*X_WIDTH  customer x per lane, same packing as cup_x
- hit  out  NUM_LANES  one-cycle pulse per lane when a cup reaches its customer
- miss  out  NUM_LANES  one-cycle pulse per lane when a customer reaches the bartender
- score  out  8  hits this game; saturates at 255
- lives  out  3  remaining lives
- playing  out  1  FSM is in PLAY
- game_over  out  1  FSM is in OVER

## Operation
- FSM states: IDLE, PLAY, OVER.
  - IDLE -> PLAY on start.
  - PLAY -> OVER when lives would become 0.
  - OVER -> PLAY on start.
  - start is ignored while in PLAY.
- Entering PLAY loads:
  - all cup_x = PLAYER_X-CUP_W, cup_active = 0
  - all cust_x = CUS_MIN_X
  - score = 0, lives = LIVES
  - both tick counters = 0
- Tick counters run only in PLAY.
  - cup_cnt counts 0..CUP_DELAY-1. cup_tick is asserted when cup_cnt == CUP_DELAY-1, then cup_cnt wraps to 0.
  - cust_cnt and cust_tick work the same way with CUST_DELAY.
- Throw: accepted only in PLAY, only when throw_lane < NUM_LANES, and only when cup_active[throw_lane] == 0. Otherwise it is silently dropped. On acceptance: cup_active = 1, cup_x = PLAYER_X-CUP_W.
- Cup motion: on cup_tick, every active cup moves cup_x -= CUP_STEP, floored at 0.
- Customer motion: on cust_tick, every cust_x += CUST_STEP.
- Hit condition, lane i: cup_active[i] && cup_x[i] <= cust_x[i]+CUST_W. Response:
  - hit[i] pulses
  - cup_active[i] = 0, cup_x[i] = PLAYER_X-CUP_W
  - cust_x[i] = CUS_MIN_X
  - score += 1, saturating
- Miss condition, lane i: not hit and cust_x[i]+CUST_W >= PLAYER_X. Response: miss[i] pulses, cust_x[i] = CUS_MIN_X.
- Lives decrement by popcount(miss), floored at 0. If the result is 0, the next state is OVER.
- All comparisons and sums use X_WIDTH+1 bits; no wraparound.
- Per-lane priority within one cycle: hit > miss > movement. A throw arriving on a lane that hits in the same cycle is dropped, because that cup was still active.
- In IDLE and OVER, positions, score and lives hold. hit and miss are 0.

## Timing
- All outputs are registered. Reset values:
  - FSM = IDLE
  - cup_x = PLAYER_X-CUP_W, cup_active = 0
  - cust_x = CUS_MIN_X
  - hit = 0, miss = 0
  - score = 0, lives = LIVES
  - playing = 0, game_over = 0
- Any assertion of rst (async) returns every output to its reset value immediately, including mid-game.
- start at edge N: playing = 1 and all state is reinitialised at N+1.
- Throw at edge N: cup_active = 1 at N+1. First cup decrement occurs on the first cup_tick after N+1.
- hit, miss, score and lives all update on the same edge the condition is detected on, evaluated from the registered positions.
- The transition to OVER and the final lives value appear on the same edge.

## Test plan
- Reset: hold rst = 0 for 3 cycles. All outputs must equal their reset values: lives = 3, cup_x = 380, cust_x = 60, playing = 0.
- Hit (NUM_LANES=4, CUP_DELAY=2, CUST_DELAY=100000, CUP_STEP=4):
  - Pulse start, then throw lane 0.
  - The cup must step 380 -> 376 -> … and hit when cup_x reaches 80, i.e. 75 steps.
  - At that edge: hit = 4'b0001, score = 1, cup_active[0] = 0, cust_x[0] = 60.
- Miss/over (CUST_DELAY=2, CUST_STEP=4, LIVES=3):
  - Play with no throws.
  - At cust_x = 380, miss = 4'b1111, lives = 0, game_over = 1, playing = 0 on the same edge.
  - Positions must then hold.
- Dropped throws:
  - A throw on lane 1 while cup_active[1] = 1 must leave cup_x[1] unchanged.
  - A throw with throw_lane = 3 when NUM_LANES = 3 must have no effect.
  - A throw in IDLE must have no effect.
- Restart: pulse start in OVER. On the next cycle: score = 0, lives = 3, playing = 1.
- Reset mid-flight: assert rst while a cup is active with score = 2. All outputs must return to reset values asynchronously, before the next clk edge.

Source files
------------

// File: rtl/tapper_lane_engine.sv
// tapper_lane_engine
// Game-state engine for the bar-tapper game. Each of NUM_LANES lanes holds one
// cup sliding left from the bartender and one customer walking right from the
// spawn point. The engine resolves hits, misses, score and lives, and runs the
// IDLE / PLAY / OVER game FSM.
//
// Ports:
//   clk          system clock
//   rst          asynchronous active-low reset
//   start        one-cycle pulse, starts a new game from IDLE or OVER
//   throw_valid  one-cycle pulse, throws a cup into throw_lane
//   throw_lane   lane index of the throw
//   cup_x        cup x per lane, lane i at [i*X_WIDTH +: X_WIDTH]
//   cup_active   cup i is sliding
//   cust_x       customer x per lane, same packing as cup_x
//   hit          one-cycle pulse per lane when a cup reaches its customer
//   miss         one-cycle pulse per lane when a customer reaches the bar
//   score        hits this game, saturating at 255
//   lives        remaining lives
//   playing      FSM is in PLAY
//   game_over    FSM is in OVER
module tapper_lane_engine #(
    parameter int NUM_LANES  = 4,
    parameter int LANE_W     = 2,
    parameter int X_WIDTH    = 10,
    parameter int PLAYER_X   = 400,
    parameter int CUS_MIN_X  = 60,
    parameter int CUP_W      = 20,
    parameter int CUST_W     = 20,
    parameter int CUP_DELAY  = 1000000,
    parameter int CUST_DELAY = 4000000,
    parameter int CUP_STEP   = 1,
    parameter int CUST_STEP  = 1,
    parameter int LIVES      = 3
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic                         throw_valid,
    input  logic [LANE_W-1:0]            throw_lane,
    output logic [NUM_LANES*X_WIDTH-1:0] cup_x,
    output logic [NUM_LANES-1:0]         cup_active,
    output logic [NUM_LANES*X_WIDTH-1:0] cust_x,
    output logic [NUM_LANES-1:0]         hit,
    output logic [NUM_LANES-1:0]         miss,
    output logic [7:0]                   score,
    output logic [2:0]                   lives,
    output logic                         playing,
    output logic                         game_over
);

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_PLAY = 2'd1, S_OVER = 2'd2} state_t;

    localparam int CUP_CW  = (CUP_DELAY  > 1) ? $clog2(CUP_DELAY)  : 1;
    localparam int CUST_CW = (CUST_DELAY > 1) ? $clog2(CUST_DELAY) : 1;

    localparam logic [X_WIDTH-1:0] LAUNCH_X    = X_WIDTH'(PLAYER_X - CUP_W);
    localparam logic [X_WIDTH-1:0] SPAWN_X     = X_WIDTH'(CUS_MIN_X);
    localparam logic [X_WIDTH-1:0] CUP_STEP_X  = X_WIDTH'(CUP_STEP);
    localparam logic [X_WIDTH-1:0] CUST_STEP_X = X_WIDTH'(CUST_STEP);
    localparam logic [X_WIDTH:0]   CUP_STEP_E  = (X_WIDTH+1)'(CUP_STEP);
    localparam logic [X_WIDTH:0]   CUST_W_E    = (X_WIDTH+1)'(CUST_W);
    localparam logic [X_WIDTH:0]   PLAYER_X_E  = (X_WIDTH+1)'(PLAYER_X);
    localparam logic [CUP_CW-1:0]  CUP_LAST    = CUP_CW'(CUP_DELAY - 1);
    localparam logic [CUST_CW-1:0] CUST_LAST   = CUST_CW'(CUST_DELAY - 1);
    localparam logic [CUP_CW-1:0]  CUP_ONE     = CUP_CW'(1);
    localparam logic [CUST_CW-1:0] CUST_ONE    = CUST_CW'(1);
    localparam logic [2:0]         LIVES_INIT  = 3'(LIVES);

    // Number of set bits in a per-lane vector (NUM_LANES <= 8 fits in 4 bits).
    function automatic logic [3:0] count_ones(input logic [NUM_LANES-1:0] v);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < NUM_LANES; i++) begin
            n = n + {3'd0, v[i]};
        end
        return n;
    endfunction

    // Cup has reached the customer's right edge; one extra bit so the sum never wraps.
    function automatic logic cup_at_cust(input logic [X_WIDTH-1:0] cup, input logic [X_WIDTH-1:0] cust);
        return ({1'b0, cup} <= ({1'b0, cust} + CUST_W_E));
    endfunction

    // Customer's right edge has reached the bartender.
    function automatic logic cust_at_bar(input logic [X_WIDTH-1:0] cust);
        return (({1'b0, cust} + CUST_W_E) >= PLAYER_X_E);
    endfunction

    state_t                         state_r, state_nxt_s;
    logic [NUM_LANES*X_WIDTH-1:0]   cup_x_r, cup_x_nxt_s;
    logic [NUM_LANES*X_WIDTH-1:0]   cust_x_r, cust_x_nxt_s;
    logic [NUM_LANES-1:0]           cup_active_r, cup_act_nxt_s;
    logic [NUM_LANES-1:0]           hit_r, hit_nxt_s, miss_r, miss_nxt_s;
    logic [7:0]                     score_r, score_nxt_s;
    logic [2:0]                     lives_r, lives_nxt_s, lives_left_s;
    logic                           playing_r, game_over_r;
    logic [CUP_CW-1:0]              cup_cnt_r, cup_cnt_nxt_s;
    logic [CUST_CW-1:0]             cust_cnt_r, cust_cnt_nxt_s;
    logic                           cup_tick_s, cust_tick_s;
    logic [NUM_LANES-1:0]           hit_det_s, miss_det_s, throw_s;
    logic [8:0]                     score_sum_s;
    logic [3:0]                     miss_cnt_s;

    // Per-lane event detection from the registered positions.
    always_comb begin
        hit_det_s  = '0;
        miss_det_s = '0;
        throw_s    = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            hit_det_s[i]  = cup_active_r[i] && cup_at_cust(cup_x_r[i*X_WIDTH +: X_WIDTH], cust_x_r[i*X_WIDTH +: X_WIDTH]);
            miss_det_s[i] = !hit_det_s[i] && cust_at_bar(cust_x_r[i*X_WIDTH +: X_WIDTH]);
            // Lanes beyond NUM_LANES never match, so such throws fall away.
            throw_s[i]    = throw_valid && (int'(throw_lane) == i) && !cup_active_r[i];
        end
        cup_tick_s   = (cup_cnt_r == CUP_LAST);
        cust_tick_s  = (cust_cnt_r == CUST_LAST);
        score_sum_s  = {1'b0, score_r} + {5'd0, count_ones(hit_det_s)};
        miss_cnt_s   = count_ones(miss_det_s);
        lives_left_s = (miss_cnt_s >= {1'b0, lives_r}) ? 3'd0 : (lives_r - miss_cnt_s[2:0]);
    end

    // Game FSM next state plus all lane / score / lives updates.
    always_comb begin
        state_nxt_s    = state_r;
        cup_x_nxt_s    = cup_x_r;
        cup_act_nxt_s  = cup_active_r;
        cust_x_nxt_s   = cust_x_r;
        hit_nxt_s      = '0;
        miss_nxt_s     = '0;
        score_nxt_s    = score_r;
        lives_nxt_s    = lives_r;
        cup_cnt_nxt_s  = cup_cnt_r;
        cust_cnt_nxt_s = cust_cnt_r;
        case (state_r)
            S_IDLE, S_OVER: begin
                if (start) begin
                    state_nxt_s    = S_PLAY;
                    cup_x_nxt_s    = {NUM_LANES{LAUNCH_X}};
                    cup_act_nxt_s  = '0;
                    cust_x_nxt_s   = {NUM_LANES{SPAWN_X}};
                    score_nxt_s    = 8'd0;
                    lives_nxt_s    = LIVES_INIT;
                    cup_cnt_nxt_s  = '0;
                    cust_cnt_nxt_s = '0;
                end else begin
                    state_nxt_s = state_r;
                end
            end
            S_PLAY: begin
                cup_cnt_nxt_s  = cup_tick_s  ? '0 : (cup_cnt_r + CUP_ONE);
                cust_cnt_nxt_s = cust_tick_s ? '0 : (cust_cnt_r + CUST_ONE);
                for (int i = 0; i < NUM_LANES; i++) begin
                    if (hit_det_s[i]) begin
                        // Hit wins the lane: a same-cycle throw is dropped (cup still active).
                        cup_act_nxt_s[i]                   = 1'b0;
                        cup_x_nxt_s[i*X_WIDTH +: X_WIDTH]  = LAUNCH_X;
                        cust_x_nxt_s[i*X_WIDTH +: X_WIDTH] = SPAWN_X;
                    end else begin
                        if (miss_det_s[i]) begin
                            cust_x_nxt_s[i*X_WIDTH +: X_WIDTH] = SPAWN_X;
                        end else if (cust_tick_s) begin
                            cust_x_nxt_s[i*X_WIDTH +: X_WIDTH] = cust_x_r[i*X_WIDTH +: X_WIDTH] + CUST_STEP_X;
                        end else begin
                            cust_x_nxt_s[i*X_WIDTH +: X_WIDTH] = cust_x_r[i*X_WIDTH +: X_WIDTH];
                        end
                        if (throw_s[i]) begin
                            cup_act_nxt_s[i]                  = 1'b1;
                            cup_x_nxt_s[i*X_WIDTH +: X_WIDTH] = LAUNCH_X;
                        end else if (cup_active_r[i] && cup_tick_s) begin
                            // Slide left, floored at zero.
                            cup_x_nxt_s[i*X_WIDTH +: X_WIDTH] =
                                ({1'b0, cup_x_r[i*X_WIDTH +: X_WIDTH]} >= CUP_STEP_E) ?
                                (cup_x_r[i*X_WIDTH +: X_WIDTH] - CUP_STEP_X) : '0;
                        end else begin
                            cup_x_nxt_s[i*X_WIDTH +: X_WIDTH] = cup_x_r[i*X_WIDTH +: X_WIDTH];
                        end
                    end
                end
                hit_nxt_s   = hit_det_s;
                miss_nxt_s  = miss_det_s;
                score_nxt_s = score_sum_s[8] ? 8'hFF : score_sum_s[7:0];
                lives_nxt_s = lives_left_s;
                if (lives_left_s == 3'd0) begin
                    state_nxt_s = S_OVER;
                end else begin
                    state_nxt_s = S_PLAY;
                end
            end
            default: begin
                state_nxt_s = S_IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r      <= S_IDLE;
            cup_x_r      <= {NUM_LANES{LAUNCH_X}};
            cup_active_r <= '0;
            cust_x_r     <= {NUM_LANES{SPAWN_X}};
            hit_r        <= '0;
            miss_r       <= '0;
            score_r      <= 8'd0;
            lives_r      <= LIVES_INIT;
            playing_r    <= 1'b0;
            game_over_r  <= 1'b0;
            cup_cnt_r    <= '0;
            cust_cnt_r   <= '0;
        end else begin
            state_r      <= state_nxt_s;
            cup_x_r      <= cup_x_nxt_s;
            cup_active_r <= cup_act_nxt_s;
            cust_x_r     <= cust_x_nxt_s;
            hit_r        <= hit_nxt_s;
            miss_r       <= miss_nxt_s;
            score_r      <= score_nxt_s;
            lives_r      <= lives_nxt_s;
            playing_r    <= (state_nxt_s == S_PLAY);
            game_over_r  <= (state_nxt_s == S_OVER);
            cup_cnt_r    <= cup_cnt_nxt_s;
            cust_cnt_r   <= cust_cnt_nxt_s;
        end
    end

    assign cup_x      = cup_x_r;
    assign cup_active = cup_active_r;
    assign cust_x     = cust_x_r;
    assign hit        = hit_r;
    assign miss       = miss_r;
    assign score      = score_r;
    assign lives      = lives_r;
    assign playing    = playing_r;
    assign game_over  = game_over_r;

endmodule

// File: tb/tb_tapper_lane_engine.sv
// Self-checking bench for tapper_lane_engine: a lane-by-lane game model checked
// every cycle, directed scenarios with hand-computed values, and random play.
module tb_tapper_lane_engine;

    localparam int NL     = 4;
    localparam int LAUNCH = 380;
    localparam int SPAWN  = 60;
    localparam int PX     = 400;
    localparam int CUSTW  = 20;
    localparam int CUPD   = 2;
    localparam int CUSTD  = 2;
    localparam int CUPS   = 4;
    localparam int CUSTS  = 4;
    localparam int LIV    = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        throw_valid = 1'b0;
    logic [1:0]  throw_lane = 2'd0;
    logic [39:0] cup_x, cust_x;
    logic [3:0]  cup_active, hit, miss;
    logic [7:0]  score;
    logic [2:0]  lives;
    logic        playing, game_over;

    logic [29:0] cup_x3, cust_x3;
    logic [2:0]  cup_active3, hit3, miss3;
    logic [7:0]  score3;
    logic [2:0]  lives3;
    logic        playing3, game_over3;

    int n_checks = 0;
    int n_fail   = 0;

    // Game model state
    int       m_cup [NL];
    int       m_cust[NL];
    bit       m_act [NL];
    int       m_score, m_lives, m_pc;
    bit       m_play, m_over;
    bit [3:0] m_hit, m_miss;

    always #10 clk = ~clk;

    tapper_lane_engine #(
        .NUM_LANES(4), .LANE_W(2), .X_WIDTH(10), .PLAYER_X(PX), .CUS_MIN_X(SPAWN),
        .CUP_W(20), .CUST_W(CUSTW), .CUP_DELAY(CUPD), .CUST_DELAY(CUSTD),
        .CUP_STEP(CUPS), .CUST_STEP(CUSTS), .LIVES(LIV)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .throw_valid(throw_valid), .throw_lane(throw_lane),
        .cup_x(cup_x), .cup_active(cup_active), .cust_x(cust_x), .hit(hit), .miss(miss),
        .score(score), .lives(lives), .playing(playing), .game_over(game_over)
    );

    tapper_lane_engine #(
        .NUM_LANES(3), .LANE_W(2), .X_WIDTH(10), .PLAYER_X(PX), .CUS_MIN_X(SPAWN),
        .CUP_W(20), .CUST_W(CUSTW), .CUP_DELAY(CUPD), .CUST_DELAY(CUSTD),
        .CUP_STEP(CUPS), .CUST_STEP(CUSTS), .LIVES(LIV)
    ) dut3 (
        .clk(clk), .rst(rst), .start(start), .throw_valid(throw_valid), .throw_lane(throw_lane),
        .cup_x(cup_x3), .cup_active(cup_active3), .cust_x(cust_x3), .hit(hit3), .miss(miss3),
        .score(score3), .lives(lives3), .playing(playing3), .game_over(game_over3)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int ones(input bit [3:0] v);
        return int'(v[0]) + int'(v[1]) + int'(v[2]) + int'(v[3]);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NL; i++) begin
            m_cup[i] = LAUNCH; m_cust[i] = SPAWN; m_act[i] = 1'b0;
        end
        m_score = 0; m_lives = LIV; m_pc = 0;
        m_play = 1'b0; m_over = 1'b0; m_hit = '0; m_miss = '0;
    endtask

    task automatic model_step();
        bit [3:0] h, m;
        bit       cup_move, cust_move;
        h = '0; m = '0;
        if (!m_play) begin
            if (start) begin
                model_reset();
                m_play = 1'b1;
            end
        end else begin
            // Movement happens every CUPD/CUSTD-th cycle spent in play.
            cup_move  = ((m_pc % CUPD) == CUPD - 1);
            cust_move = ((m_pc % CUSTD) == CUSTD - 1);
            m_pc++;
            for (int i = 0; i < NL; i++) begin
                if (m_act[i] && (m_cup[i] <= m_cust[i] + CUSTW)) begin
                    h[i] = 1'b1;
                    m_act[i] = 1'b0; m_cup[i] = LAUNCH; m_cust[i] = SPAWN;
                end else begin
                    if (m_cust[i] + CUSTW >= PX) begin
                        m[i] = 1'b1; m_cust[i] = SPAWN;
                    end else if (cust_move) begin
                        m_cust[i] = m_cust[i] + CUSTS;
                    end
                    if (throw_valid && int'(throw_lane) == i && !m_act[i]) begin
                        m_act[i] = 1'b1; m_cup[i] = LAUNCH;
                    end else if (m_act[i] && cup_move) begin
                        m_cup[i] = (m_cup[i] >= CUPS) ? m_cup[i] - CUPS : 0;
                    end
                end
            end
            m_score = m_score + ones(h);
            if (m_score > 255) m_score = 255;
            m_lives = m_lives - ones(m);
            if (m_lives <= 0) begin
                m_lives = 0; m_play = 1'b0; m_over = 1'b1;
            end
        end
        m_hit = h; m_miss = m;
    endtask

    // Model advance
    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst);
            if (!rst) model_reset();
            else model_step();
        end
    end

    // Per-cycle compare against the model
    initial begin
        logic [39:0] e_cup, e_cust;
        logic [3:0]  e_act;
        forever begin
            @(negedge clk);
            for (int i = 0; i < NL; i++) begin
                e_cup[i*10 +: 10]  = 10'(m_cup[i]);
                e_cust[i*10 +: 10] = 10'(m_cust[i]);
                e_act[i]           = m_act[i];
            end
            chk("cyc_cup_x", cup_x, e_cup);
            chk("cyc_cust_x", cust_x, e_cust);
            chk("cyc_cup_active", cup_active, e_act);
            chk("cyc_hit", hit, m_hit);
            chk("cyc_miss", miss, m_miss);
            chk("cyc_score", score, 8'(m_score));
            chk("cyc_lives", lives, 3'(m_lives));
            chk("cyc_playing", playing, m_play);
            chk("cyc_game_over", game_over, m_over);
        end
    end

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic throw_cup(input int lane);
        throw_valid = 1'b1;
        throw_lane  = 2'(lane);
        @(negedge clk);
        throw_valid = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_cup_x"}, cup_x, {4{10'd380}});
        chk({tag, "_cust_x"}, cust_x, {4{10'd60}});
        chk({tag, "_cup_active"}, cup_active, 4'b0000);
        chk({tag, "_hit"}, hit, 4'b0000);
        chk({tag, "_miss"}, miss, 4'b0000);
        chk({tag, "_score"}, score, 8'd0);
        chk({tag, "_lives"}, lives, 3'd3);
        chk({tag, "_playing"}, playing, 1'b0);
        chk({tag, "_game_over"}, game_over, 1'b0);
    endtask

    initial begin
        int  cnt;
        bit  found;

        // Reset held for three cycles
        repeat (3) @(negedge clk);
        check_reset_values("reset");
        rst = 1'b1;
        @(negedge clk);

        // Throw in IDLE has no effect
        throw_cup(0);
        chk("idle_throw_active", cup_active, 4'b0000);
        chk("idle_throw_playing", playing, 1'b0);

        // Game 1: no throws, all four customers reach the bar together
        pulse_start();
        chk("start_playing", playing, 1'b1);
        found = 1'b0; cnt = 0;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            cnt++;
            if (miss != 4'b0000) begin found = 1'b1; break; end
        end
        chk("miss_seen", found, 1'b1);
        chk("miss_latency", cnt, 161);
        chk("miss_all", miss, 4'b1111);
        chk("over_lives", lives, 3'd0);
        chk("over_flag", game_over, 1'b1);
        chk("over_playing", playing, 1'b0);
        repeat (5) @(negedge clk);
        chk("over_hold_cust", cust_x, {4{10'd60}});
        chk("over_hold_cup", cup_x, {4{10'd380}});
        chk("over_hold_lives", lives, 3'd0);

        // Game 2: restart from OVER, single hit on lane 0
        pulse_start();
        chk("restart_score", score, 8'd0);
        chk("restart_lives", lives, 3'd3);
        chk("restart_playing", playing, 1'b1);
        throw_cup(0);
        chk("throw_active", cup_active, 4'b0001);
        found = 1'b0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (hit != 4'b0000) begin found = 1'b1; break; end
        end
        chk("hit_seen", found, 1'b1);
        chk("hit_lane0", hit, 4'b0001);
        chk("hit_score", score, 8'd1);
        chk("hit_cup_inactive", cup_active[0], 1'b0);
        chk("hit_cust_respawn", cust_x[9:0], 10'd60);

        // Lane 3 does not exist on the three-lane engine
        throw_cup(3);
        chk("lane3_dut3_active", cup_active3, 3'b000);
        chk("lane3_dut3_cup_x", cup_x3, {3{10'd380}});
        chk("lane3_dut4_active", cup_active[3], 1'b1);

        // Re-throw into a busy lane is dropped
        throw_cup(1);
        repeat (4) @(negedge clk);
        throw_cup(1);
        chk("busy_lane_moved", cup_x[19:10] < 10'd380, 1'b1);
        chk("busy_lane_active", cup_active[1], 1'b1);

        // Random play, including restarts and ignored starts
        for (int k = 0; k < 2500; k++) begin
            throw_valid = ($urandom_range(0, 3) == 0);
            throw_lane  = 2'($urandom_range(0, 3));
            start       = ($urandom_range(0, 59) == 0);
            @(negedge clk);
        end
        throw_valid = 1'b0;
        start = 1'b0;

        // Fresh game, two hits, then reset while a cup is in flight
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        pulse_start();
        throw_cup(0);
        throw_cup(1);
        found = 1'b0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (score == 8'd2) begin found = 1'b1; break; end
        end
        chk("two_hits_seen", found, 1'b1);
        chk("two_hits_lives", lives, 3'd3);
        throw_cup(2);
        chk("inflight_active", cup_active[2], 1'b1);
        #1 rst = 1'b0;
        #1;
        check_reset_values("async_reset");
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
